// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, column scan, scan-level debounce.
// Key-change event slot is built only when KEYPAD_SCANNER_EVENT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        CLK_25MHZ,
  input  logic        RESET,
  input  logic [3:0]  ROWS,
  output logic [3:0]  COLS,
  output logic [15:0] KEYS,
  output logic        EVENT_VALID,
  input  logic        EVENT_READY,
  output logic [3:0]  EVENT_CODE,
  output logic        EVENT_PRESSED
);

  localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  MATCH_MAX = 4'(DEBOUNCE_SCANS);

  logic [3:0]  rows_meta;
  logic [3:0]  rows_sync;
  logic [15:0] div;
  logic [1:0]  col;
  logic [15:0] raw;
  logic [15:0] prev;
  logic [3:0]  match;
  logic        load_keys;

  logic        tick;
  logic        scan_done;
  logic [15:0] raw_next;
  logic [3:0]  match_next;

  assign tick      = (div == DIV_LAST);
  assign scan_done = tick && (col == 2'd3);
  assign COLS      = ~(4'b0001 << col);

  always_comb begin
    raw_next = raw;
    raw_next[{col, 2'b00} +: 4] = ~rows_sync;
  end

  always_comb begin
    match_next = 4'd1;
    if (raw_next == prev) begin
      match_next = (match >= MATCH_MAX) ? MATCH_MAX
                                        : match + 4'd1;
    end
  end

  always_ff @(posedge CLK_25MHZ or negedge RESET) begin
    if (!RESET) begin
      rows_meta <= 4'b1111;
      rows_sync <= 4'b1111;
    end else begin
      rows_meta <= ROWS;
      rows_sync <= rows_meta;
    end
  end

  always_ff @(posedge CLK_25MHZ or negedge RESET) begin
    if (!RESET) begin
      div       <= '0;
      col       <= '0;
      raw       <= '0;
      prev      <= '0;
      match     <= '0;
      load_keys <= 1'b0;
      KEYS      <= '0;
    end else begin
      load_keys <= scan_done && (match_next == MATCH_MAX);
      if (load_keys) begin
        KEYS <= raw;
      end
      if (tick) begin
        div <= '0;
        col <= col + 2'd1;
        raw <= raw_next;
        if (col == 2'd3) begin
          prev  <= raw_next;
          match <= match_next;
        end
      end else begin
        div <= div + 16'd1;
      end
    end
  end

`ifdef KEYPAD_SCANNER_EVENT_EN
  logic [15:0] pending;
  logic [15:0] pending_next;
  logic [15:0] changes;
  logic [15:0] pick_mask;
  logic [3:0]  pick_idx;
  logic        slot_free;
  logic        slot_load;

  assign changes   = load_keys ? (KEYS ^ raw) : '0;
  assign slot_free = !EVENT_VALID || EVENT_READY;
  assign slot_load = slot_free && (pending != '0);

  // descending walk so the lowest set index wins
  always_comb begin
    pick_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) pick_idx = 4'(i);
    end
  end

  assign pick_mask    = slot_load ? (16'd1 << pick_idx) : '0;
  assign pending_next = (pending & ~pick_mask) | changes;

  always_ff @(posedge CLK_25MHZ or negedge RESET) begin
    if (!RESET) begin
      pending       <= '0;
      EVENT_VALID   <= 1'b0;
      EVENT_CODE    <= '0;
      EVENT_PRESSED <= 1'b0;
    end else begin
      pending <= pending_next;
      if (slot_free) begin
        EVENT_VALID <= (pending != '0);
        if (slot_load) begin
          EVENT_CODE    <= pick_idx;
          EVENT_PRESSED <= KEYS[pick_idx];
        end
      end
    end
  end
`else
  logic unused_ready;

  assign unused_ready  = EVENT_READY;
  assign EVENT_VALID   = 1'b0;
  assign EVENT_CODE    = '0;
  assign EVENT_PRESSED = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model driving ROWS from COLS,
// scan-level debounce/event reference model, per-feature tasks.
module tb_keypad_scanner;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] keys;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        ev_pressed;

  keypad_scanner #(
    .SCAN_DIV(DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .CLK_25MHZ(clk),
    .RESET(rst_n),
    .ROWS(rows),
    .COLS(cols),
    .KEYS(keys),
    .EVENT_VALID(ev_valid),
    .EVENT_READY(ev_ready),
    .EVENT_CODE(ev_code),
    .EVENT_PRESSED(ev_pressed)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] key_state = '0;
  logic        bnc_low = 1'b0;
  int          bcnt = 0;

  // physical keypad: pressed key shorts its row to the driven column
  always_comb begin
    rows = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (!cols[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (key_state[c*4+r]) rows[r] = 1'b0;
        end
      end
    end
    if (bnc_low) rows[1] = 1'b0;
  end

  logic [15:0] m_keys;
  int          m_prev;
  int          m_match;
  logic [4:0]  exp_ev[$];
  logic [4:0]  obs_ev[$];

  logic        h_valid[16];
  logic [3:0]  h_code[16];
  logic        h_pressed[16];

  function automatic void model_reset();
    m_keys  = '0;
    m_prev  = 0;
    m_match = 0;
  endfunction

  // one completed scan that saw snapshot snap
  function automatic void model_scan(input logic [15:0] snap);
    logic [15:0] diff;
    if (int'(snap) == m_prev) begin
      m_match = (m_match + 1 > DEB) ? DEB : m_match + 1;
    end else begin
      m_match = 1;
    end
    m_prev = int'(snap);
    if (m_match == DEB) begin
      diff = m_keys ^ snap;
`ifdef KEYPAD_SCANNER_EVENT_EN
      for (int i = 0; i < 16; i++) begin
        if (diff[i]) exp_ev.push_back({4'(i), snap[i]});
      end
`endif
      m_keys = snap;
    end
  endfunction

  task automatic run_scan(input logic [15:0] k,
                          input bit bounce,
                          input int ready_from);
    logic [3:0] exp_cols;
    key_state = k;
    for (int i = 0; i < 16; i++) begin
      bnc_low = bounce && ((bcnt / 5) % 2 == 0);
      if (bounce) bcnt++;
      ev_ready = (i >= ready_from);
      #1;
      exp_cols = ~(4'b0001 << (i / 4));
      vectors++;
      if (cols !== exp_cols) begin
        miscompares++;
        $display("FAIL cols cyc%0d: got %b want %b", i, cols, exp_cols);
      end
      if (i == 1) begin
        vectors++;
        if (keys !== m_keys) begin
          miscompares++;
          $display("FAIL keys: got %h want %h", keys, m_keys);
        end
      end
`ifndef KEYPAD_SCANNER_EVENT_EN
      vectors++;
      if ({ev_valid, ev_code, ev_pressed} !== 6'd0) begin
        miscompares++;
        $display("FAIL ev_tied: got v%b c%0d p%b want 0",
                 ev_valid, ev_code, ev_pressed);
      end
`endif
      h_valid[i]   = ev_valid;
      h_code[i]    = ev_code;
      h_pressed[i] = ev_pressed;
      if (ev_valid === 1'b1 && ev_ready)
        obs_ev.push_back({ev_code, ev_pressed});
      @(posedge clk);
      @(negedge clk);
    end
    bnc_low = 1'b0;
    if (!bounce) model_scan(k);
  endtask

  task automatic compare_events(input string tag);
    int n;
    vectors++;
    if (obs_ev.size() != exp_ev.size()) begin
      miscompares++;
      $display("FAIL %s ev_count: got %0d want %0d",
               tag, obs_ev.size(), exp_ev.size());
    end
    n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size()
                                        : exp_ev.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (obs_ev[i] !== exp_ev[i]) begin
        miscompares++;
        $display("FAIL %s ev%0d: got code %0d p%b want code %0d p%b",
                 tag, i, obs_ev[i][4:1], obs_ev[i][0],
                 exp_ev[i][4:1], exp_ev[i][0]);
      end
    end
    obs_ev.delete();
    exp_ev.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if ({cols, keys, ev_valid, ev_code, ev_pressed} !==
        {4'b1110, 16'h0000, 1'b0, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got cols %b keys %h v%b c%0d p%b want 1110 0000 0 0 0",
               tag, cols, keys, ev_valid, ev_code, ev_pressed);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ev_ready = 1'b1;
    key_state = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    repeat (4) run_scan(16'h0000, 1'b0, 0);
    compare_events("idle");
  endtask

  task automatic test_key_hold();
    repeat (4) run_scan(16'h0200, 1'b0, 0);
    vectors++;
    if (keys !== 16'h0200) begin
      miscompares++;
      $display("FAIL hold_keys: got %h want 0200", keys);
    end
    repeat (4) run_scan(16'h0000, 1'b0, 0);
    compare_events("key_hold");
  endtask

  task automatic test_key5();
    repeat (4) run_scan(16'h0020, 1'b0, 0);
    vectors++;
    if (keys !== 16'h0020) begin
      miscompares++;
      $display("FAIL key5: got %h want 0020", keys);
    end
    repeat (4) run_scan(16'h0000, 1'b0, 0);
    compare_events("key5");
  endtask

  task automatic test_bounce();
    bcnt = 0;
    repeat (3) run_scan(16'h0000, 1'b1, 0);
    // bounced scans never repeat, so debounce history is unknown
    m_prev = -1;
    repeat (4) run_scan(16'h2222, 1'b0, 0);
    vectors++;
    if (keys !== 16'h2222) begin
      miscompares++;
      $display("FAIL bounce_steady: got %h want 2222", keys);
    end
    repeat (4) run_scan(16'h0000, 1'b0, 0);
    compare_events("bounce");
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes[4];
    codes = '{4'd3, 4'd6, 4'd10, 4'd12};
    repeat (4) run_scan(16'h1448, 1'b0, 0);
`ifdef KEYPAD_SCANNER_EVENT_EN
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (!(h_valid[2+i] === 1'b1 && h_code[2+i] === codes[i])) begin
        miscompares++;
        $display("FAIL b2b cyc%0d: got v%b c%0d want v1 c%0d",
                 2 + i, h_valid[2+i], h_code[2+i], codes[i]);
      end
    end
    vectors++;
    if (h_valid[6] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got v%b want 0", h_valid[6]);
    end
`endif
    repeat (4) run_scan(16'h0000, 1'b0, 0);
    compare_events("b2b");
  endtask

  task automatic test_holdoff();
    logic [5:0] want;
    repeat (3) run_scan(16'h8001, 1'b0, 0);
    run_scan(16'h8001, 1'b0, 16);
`ifdef KEYPAD_SCANNER_EVENT_EN
    want = {1'b1, 4'd0, 1'b1};
    for (int i = 2; i < 16; i++) begin
      vectors++;
      if ({h_valid[i], h_code[i], h_pressed[i]} !== want) begin
        miscompares++;
        $display("FAIL holdA cyc%0d: got v%b c%0d p%b want v1 c0 p1",
                 i, h_valid[i], h_code[i], h_pressed[i]);
      end
    end
`endif
    run_scan(16'h8001, 1'b0, 6);
`ifdef KEYPAD_SCANNER_EVENT_EN
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if ({h_valid[i], h_code[i], h_pressed[i]} !== want) begin
        miscompares++;
        $display("FAIL holdB cyc%0d: got v%b c%0d p%b want v1 c0 p1",
                 i, h_valid[i], h_code[i], h_pressed[i]);
      end
    end
    vectors++;
    if ({h_valid[7], h_code[7], h_pressed[7]} !== {1'b1, 4'd15, 1'b1}) begin
      miscompares++;
      $display("FAIL hold15: got v%b c%0d p%b want v1 c15 p1",
               h_valid[7], h_code[7], h_pressed[7]);
    end
    vectors++;
    if (h_valid[8] !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_idle: got v%b want 0", h_valid[8]);
    end
`endif
    repeat (4) run_scan(16'h0000, 1'b0, 0);
    compare_events("holdoff");
  endtask

  task automatic test_random();
    logic [15:0] k;
    int hold;
    k = '0;
    for (int n = 0; n < 12; n++) begin
      k = 16'($urandom);
      hold = $urandom_range(1, 5);
      repeat (hold) run_scan(k, 1'b0, 0);
    end
    repeat (4) run_scan(k, 1'b0, 0);
    repeat (4) run_scan(16'h0000, 1'b0, 0);
    compare_events("random");
  endtask

  task automatic test_mid_reset();
    repeat (4) run_scan(16'h0001, 1'b0, 0);
    vectors++;
    if (keys !== 16'h0001) begin
      miscompares++;
      $display("FAIL pre_reset_keys: got %h want 0001", keys);
    end
    compare_events("pre_reset");
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    key_state = '0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_reset_hold");
    rst_n = 1'b1;
    model_reset();
    repeat (4) run_scan(16'h0000, 1'b0, 0);
    compare_events("post_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    ev_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_idle();
    test_key_hold();
    test_key5();
    test_bounce();
    test_back_to_back();
    test_holdoff();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, meaning clock cycles each column is driven (1 ms at 25 MHz); legal range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive identical full scans required before KEYS updates; legal range 1..15.
REQ-003 SHALL have port CLK_25MHZ  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ROWS  input  4  keypad row lines, externally pulled up; low = pressed key in driven column.
REQ-006 SHALL have port COLS  output  4  one-cold column drive; active column low, others high.
REQ-007 SHALL have port KEYS  output  16  debounced key state, bit (col*4+row), 1 = pressed.
REQ-008 SHALL have port EVENT_VALID  output  1  key-change event available.
REQ-009 SHALL have port EVENT_READY  input  1  consumer accepts event.
REQ-010 SHALL have port EVENT_CODE  output  4  key index of event.
REQ-011 SHALL have port EVENT_PRESSED  output  1  1 = press, 0 = release.

Function
REQ-012 SHALL pass ROWS through a 2-flop synchronizer before any use.
REQ-013 SHALL run divider counter 0..SCAN_DIV-1; at count SCAN_DIV-1 SHALL capture ~ROWS_sync into raw bits [col*4+3:col*4], then advance column 0->1->2->3->0 and rewrite COLS next cycle.
REQ-014 Scan period SHALL be exactly 4*SCAN_DIV cycles; COLS SHALL never have more or fewer than one low bit.
REQ-015 On the capture for column 3 (scan complete): if raw == previous scan, match counter increments (saturating at DEBOUNCE_SCANS); otherwise counter SHALL reset to 1; previous scan <= raw.
REQ-016 KEYS SHALL load raw on the cycle after a scan-complete capture where the match counter reaches DEBOUNCE_SCANS; with DEBOUNCE_SCANS=1 every completed scan loads KEYS.
REQ-017 On each KEYS update, changed bits (old XOR new) SHALL be OR-ed into a 16-bit pending mask.
REQ-018 When the event slot is empty, or being consumed (VALID and READY), and pending is nonzero, the slot SHALL load lowest-index pending bit next cycle: CODE = index, PRESSED = current KEYS bit; that pending bit clears.
REQ-019 EVENT_CODE/EVENT_PRESSED SHALL be stable while EVENT_VALID=1 and EVENT_READY=0; VALID deasserts only after handshake with nothing pending.
REQ-020 Simultaneous KEYS update and slot load SHALL merge: new changes enter pending, the bit loaded that cycle clears; no change lost.
REQ-021 Back-to-back events SHALL sustain one per cycle with READY held high.
REQ-022 EVENT_READY while EVENT_VALID=0 SHALL have no effect.

Reset
REQ-023 RESET low SHALL asynchronously set: divider 0, column 0, COLS=4'b1110, synchronizer 4'b1111, raw/previous 0, match counter 0, KEYS=0, pending 0, EVENT_VALID=0, EVENT_CODE=0, EVENT_PRESSED=0.
REQ-024 Release mid-scan SHALL restart scanning from column 0 with divider 0; no event from pre-reset state.

Configuration
REQ-025 Macro KEYPAD_SCANNER_EVENT_EN defined: event path (REQ-017..REQ-022) present.
REQ-026 Macro undefined: pending mask and slot SHALL be absent; EVENT_VALID, EVENT_CODE, EVENT_PRESSED tied 0; EVENT_READY ignored; KEYS behaviour unchanged.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3, macro defined unless noted)
REQ-027 Reset release, no keys -> COLS cycles 1110,1101,1011,0111, 4 cycles each; KEYS=0; no events.
REQ-028 Hold key row1/col2 -> KEYS=16'h0200 after 3rd identical scan; one event CODE=9 PRESSED=1; on release, event CODE=9 PRESSED=0.
REQ-029 Row1 toggling every 5 cycles (bounce) for 3 scans -> KEYS stays 0, no event; then steady -> KEYS updates after 3 clean scans.
REQ-030 Press keys 0 and 15 same scan, READY low 20 cycles -> CODE=0 held stable; READY high -> CODE=15 next cycle, then VALID low.
REQ-031 RESET low mid-scan with KEYS=16'h0001 -> all outputs at reset values same cycle; after release scan restarts at column 0.
REQ-032 Macro undefined, key 5 held -> KEYS=16'h0020; EVENT_VALID stays 0.
